// File: rtl/test_master_slave_writer.sv
// Producer for slave-style <name>/<name>_sync port pairs: emits val on s_out,
// then after GAP idle cycles emits the (possibly incremented or reloaded) val on s_out2.
module test_master_slave_writer #(
    parameter logic [31:0] INIT_VAL = 32'd1337,
    parameter int unsigned GAP      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] s_out,
    output logic        s_out_sync,
    output logic [31:0] s_out2,
    output logic        s_out2_sync,
    output logic        section_o
);

    typedef enum logic {
        SECTION_A = 1'b0,
        SECTION_B = 1'b1
    } section_t;

    localparam logic [7:0] GAP_CNT = 8'(GAP);

    section_t    section;
    logic [31:0] val;
    logic [7:0]  cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            section     <= SECTION_A;
            val         <= INIT_VAL;
            cnt         <= 8'd0;
            s_out       <= 32'd0;
            s_out2      <= 32'd0;
            s_out_sync  <= 1'b0;
            s_out2_sync <= 1'b0;
            section_o   <= 1'b0;
        end else begin
            s_out_sync  <= 1'b0;
            s_out2_sync <= 1'b0;
            case (section)
                SECTION_A: begin
                    if (en) begin
                        s_out      <= val;
                        s_out_sync <= 1'b1;
                        val        <= val + 32'd1;
                        cnt        <= 8'd0;
                        section    <= SECTION_B;
                        section_o  <= 1'b1;
                    end
                end
                SECTION_B: begin
                    if (cnt == GAP_CNT) begin
                        s_out2      <= val;
                        s_out2_sync <= 1'b1;
                        cnt         <= 8'd0;
                        section     <= SECTION_A;
                        section_o   <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    section   <= SECTION_A;
                    section_o <= 1'b0;
                end
            endcase
            // A load overrides the increment above; writes this cycle still see the old val.
            if (load) val <= load_val;
        end
    end

endmodule

// File: tb/tb_test_master_slave_writer.sv
// Randomised scoreboard bench: two writers (GAP=2 and GAP=0) share stimulus; a timeline
// model predicts each sync pulse's edge and data, a negedge monitor pops and compares.
module tb_test_master_slave_writer;

    localparam logic [31:0] INIT = 32'd1337;

    typedef struct {
        int          stream;
        int          k;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        int   k;
        logic sec;
    } sec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [31:0] load_val = 32'd0;

    logic [31:0] a_s_out, a_s_out2, b_s_out, b_s_out2;
    logic        a_s_out_sync, a_s_out2_sync, a_section_o;
    logic        b_s_out_sync, b_s_out2_sync, b_section_o;

    test_master_slave_writer #(.INIT_VAL(INIT), .GAP(2)) u_dut_gap2 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .s_out(a_s_out), .s_out_sync(a_s_out_sync),
        .s_out2(a_s_out2), .s_out2_sync(a_s_out2_sync), .section_o(a_section_o)
    );

    test_master_slave_writer #(.INIT_VAL(INIT), .GAP(0)) u_dut_gap0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .s_out(b_s_out), .s_out_sync(b_s_out_sync),
        .s_out2(b_s_out2), .s_out2_sync(b_s_out2_sync), .section_o(b_section_o)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    int n_chk = 0;
    int n_fail = 0;

    // model state: per instance, the earliest edge that may accept en and the pending s_out2 edge
    int          gaps[2];
    int          free_e[2];
    int          pend_e[2];
    logic [31:0] mval[2];
    ev_t         q0[$];
    ev_t         q1[$];
    sec_t        sq0[$];
    sec_t        sq1[$];
    logic [31:0] prev1[2];
    logic [31:0] prev2[2];
    logic        prevs1[2];
    logic        prevs2[2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ev_t qfront(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    function automatic ev_t qpop(input int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic int sqsize(input int i);
        return (i == 0) ? sq0.size() : sq1.size();
    endfunction

    function automatic sec_t sqfront(input int i);
        return (i == 0) ? sq0[0] : sq1[0];
    endfunction

    function automatic sec_t sqpop(input int i);
        if (i == 0) return sq0.pop_front();
        return sq1.pop_front();
    endfunction

    function automatic void push_ev(input int i, input ev_t ev);
        if (i == 0) q0.push_back(ev);
        else q1.push_back(ev);
    endfunction

    function automatic void push_sec(input int i, input sec_t s);
        if (i == 0) sq0.push_back(s);
        else sq1.push_back(s);
    endfunction

    // Drive one edge's inputs and predict what each writer emits at that edge.
    task automatic step(input logic e, input logic l, input logic [31:0] lv);
        int   k;
        logic acc;
        en = e;
        load = l;
        load_val = lv;
        k = ecnt;
        for (int i = 0; i < 2; i++) begin
            acc = e && (k >= free_e[i]);
            if (pend_e[i] == k) push_ev(i, '{2, k, mval[i]});
            if (acc) begin
                push_ev(i, '{1, k, mval[i]});
                pend_e[i] = k + 1 + gaps[i];
                free_e[i] = k + 2 + gaps[i];
            end
            push_sec(i, '{k, acc || (pend_e[i] > k)});
            mval[i] = l ? lv : (acc ? mval[i] + 32'd1 : mval[i]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        sq0.delete();
        sq1.delete();
        for (int i = 0; i < 2; i++) begin
            mval[i] = INIT;
            pend_e[i] = -1;
            free_e[i] = 0;
        end
    endtask

    task automatic mon(input int i, input logic [31:0] d1, input logic s1,
                       input logic [31:0] d2, input logic s2, input logic sec);
        int   j;
        ev_t  ev;
        sec_t se;
        string p;
        j = ecnt - 1;
        p = $sformatf("inst%0d", i);
        while (qsize(i) > 0 && qfront(i).k < j) begin
            ev = qpop(i);
            n_chk++;
            n_fail++;
            $display("FAIL %s missed pulse: stream %0d at edge %0d got none expected data 0x%08h",
                     p, ev.stream, ev.k, ev.data);
        end
        chk({p, " both syncs"}, {31'd0, s1 && s2}, 32'd0);
        chk({p, " s_out_sync repeat"}, {31'd0, s1 && prevs1[i]}, 32'd0);
        chk({p, " s_out2_sync repeat"}, {31'd0, s2 && prevs2[i]}, 32'd0);
        if (s1 || s2) begin
            if (qsize(i) == 0 || qfront(i).k != j) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s unexpected pulse at edge %0d: got s1=%0b s2=%0b expected none",
                         p, j, s1, s2);
            end else begin
                ev = qpop(i);
                chk({p, " stream"}, s1 ? 32'd1 : 32'd2, ev.stream);
                chk({p, " data"}, s1 ? d1 : d2, ev.data);
            end
        end
        if (!s1) chk({p, " s_out hold"}, d1, prev1[i]);
        if (!s2) chk({p, " s_out2 hold"}, d2, prev2[i]);
        while (sqsize(i) > 0 && sqfront(i).k < j) se = sqpop(i);
        if (sqsize(i) > 0 && sqfront(i).k == j) begin
            se = sqpop(i);
            chk({p, " section_o"}, {31'd0, sec}, {31'd0, se.sec});
        end
        prev1[i] = d1;
        prev2[i] = d2;
        prevs1[i] = s1;
        prevs2[i] = s2;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                prev1[m] = 32'd0;
                prev2[m] = 32'd0;
                prevs1[m] = 1'b0;
                prevs2[m] = 1'b0;
            end
        end else begin
            mon(0, a_s_out, a_s_out_sync, a_s_out2, a_s_out2_sync, a_section_o);
            mon(1, b_s_out, b_s_out_sync, b_s_out2, b_s_out2_sync, b_section_o);
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " a s_out"}, a_s_out, 32'd0);
        chk({tag, " a s_out2"}, a_s_out2, 32'd0);
        chk({tag, " a syncs"}, {30'd0, a_s_out_sync, a_s_out2_sync}, 32'd0);
        chk({tag, " a section_o"}, {31'd0, a_section_o}, 32'd0);
        chk({tag, " b s_out"}, b_s_out, 32'd0);
        chk({tag, " b s_out2"}, b_s_out2, 32'd0);
        chk({tag, " b syncs"}, {30'd0, b_s_out_sync, b_s_out2_sync}, 32'd0);
        chk({tag, " b section_o"}, {31'd0, b_section_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] lv;
        int          r;
        gaps[0] = 2;
        gaps[1] = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outputs("reset");
        for (int i = 0; i < 2; i++) free_e[i] = ecnt;

        // single pair, then en held high
        step(1'b1, 1'b0, 32'd0);
        repeat (6) step(1'b0, 1'b0, 32'd0);
        repeat (8) step(1'b1, 1'b0, 32'd0);
        repeat (5) step(1'b0, 1'b0, 32'd0);

        // asynchronous reset while GAP=2 writer sits in B with cnt=1
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk_reset_outputs("async rst");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) free_e[i] = ecnt;
        step(1'b1, 1'b0, 32'd0);
        repeat (5) step(1'b0, 1'b0, 32'd0);

        // wrap from 0xFFFFFFFF, load racing the increment, en toggled in B
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 32'd0);
        repeat (5) step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'd5);
        repeat (5) step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h7FFF_FFFF);
        step(1'b1, 1'b0, 32'd0);
        repeat (5) step(1'b0, 1'b0, 32'd0);

        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 3));
            lv = (r == 0) ? 32'h7FFF_FFFF : (r == 1) ? 32'hFFFF_FFFF : $urandom;
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), lv);
        end
        repeat (8) step(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        #1;
        chk("inst0 undelivered pulses", qsize(0), 32'd0);
        chk("inst1 undelivered pulses", qsize(1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/test_master_slave_writer.md
# test_master_slave_writer

Producer for the slave-style `<name>` / `<name>_sync` port pairs used by the TestMasterSlave family of blocks. It is a two-section state machine holding a 32-bit value register, and it drives two slave output streams, each with a one-cycle sync pulse. The block is the transmitting end that feeds consumer modules taking `s_in`/`s_in_sync` and `s_in2`/`s_in2_sync` inputs. It sits alongside those modules in the PrintSkeleton test designs.

## Interface
Parameters:
- `INIT_VAL`, default 1337: reset value of the internal value register `val`.
- `GAP`, default 2: number of idle cycles spent in SECTION_B before the second write. Legal range is 0..255.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  request to emit one write pair; sampled only in SECTION_A.
- `load`  in  1  overwrite `val` with `load_val`; accepted in any section.
- `load_val`  in  32  value written to `val` when `load`=1.
- `s_out`  out  32  first stream data, registered; holds its last value between pulses.
- `s_out_sync`  out  1  high for exactly one cycle per `s_out` write.
- `s_out2`  out  32  second stream data, registered; holds its last value.
- `s_out2_sync`  out  1  high for exactly one cycle per `s_out2` write.
- `section_o`  out  1  current section: 0 = SECTION_A, 1 = SECTION_B.

## Operation
- Internal state:
  - section register (SECTION_A, SECTION_B);
  - `val` (32-bit, two's-complement integer);
  - `cnt` (8-bit gap counter).
- Reset, asynchronous, takes effect immediately:
  - section = SECTION_A, `val` = INIT_VAL, `cnt` = 0;
  - `s_out` = 0, `s_out2` = 0, `s_out_sync` = 0, `s_out2_sync` = 0, `section_o` = 0.
- SECTION_A:
  - `en`=0: stay in A; both syncs drive 0.
  - `en`=1:
    - `s_out` <= `val`, `s_out_sync` <= 1;
    - `val` <= `val`+1, wrapping modulo 2^32 (0x7FFFFFFF+1 = 0x80000000; 0xFFFFFFFF+1 = 0);
    - `cnt` <= 0; go to SECTION_B.
- SECTION_B:
  - `en` is ignored.
  - If `cnt` == GAP:
    - `s_out2` <= `val`, `s_out2_sync` <= 1;
    - `cnt` <= 0; go to SECTION_A.
  - Else `cnt` <= `cnt`+1; stay in B; syncs 0.
- Load:
  - When `load`=1, `val` <= `load_val`. This takes precedence over the increment in the same cycle.
  - Any write issued in that same cycle uses the old `val`, the value before the edge.
- Sync outputs are never high in two consecutive cycles on the same stream.
- `s_out_sync` and `s_out2_sync` are never high in the same cycle.
- Data outputs change only on a cycle where their own sync is asserted.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Latency:
  - `en` sampled at edge E0 (in A) gives `s_out_sync`=1 during the cycle after E0.
  - `s_out2_sync`=1 during the cycle after edge E0+1+GAP.
- With GAP=0:
  - the two pulses fall in back-to-back cycles;
  - peak throughput is one pair per 2 cycles when `en` is held high.
- General period with `en` held high: GAP+2 cycles per pair.
- `section_o` reflects the section register and updates on the same edge as the transition.
- Reset asserted mid-operation, for example in B with `cnt`=1:
  - outputs go to their reset values without waiting for a clock;
  - the pending `s_out2` write is discarded;
  - after deassertion, the first possible `en` sample is the next rising edge.
- `load` on the emission edge in B:
  - `s_out2` shows the old `val`;
  - the next `s_out` shows `load_val`.

## Test plan
- Reset, then `en`=1 for one cycle, GAP=2 -> cycle 1 after the sample: `s_out`=1337 with `s_out_sync`=1. Cycle 4: `s_out2`=1338 with `s_out2_sync`=1. `section_o` reads 1 for cycles 1-3.
- `en` held high, GAP=0, 3 pairs -> syncs alternate every cycle. `s_out` = 1337, 1338, 1339. `s_out2` = 1338, 1339, 1340.
- `load`=1 with `load_val`=0xFFFFFFFF, then `en` -> `s_out`=0xFFFFFFFF and `s_out2`=0x00000000 (wrap).
- `load`=1 with `load_val`=5 on the same edge that samples `en` in A -> `s_out`=1337, then `s_out2`=5 (load beats the increment).
- `en` toggled while in B -> ignored: only one `s_out_sync` pulse occurs before returning to A.
- `rst` pulsed asynchronously while in B with `cnt`=1 -> outputs are 0 immediately and no `s_out2_sync` follows. The next `en` produces `s_out`=1337.
